// File: rtl/toysram_scan_ctl_if.sv
// rtl/toysram_scan_ctl_if.sv - pad-side scan bundle and parallel status/config word of the scan controller
// master = pad/test driver side, slave = toysram_scan_ctl.
interface toysram_scan_ctl_if #(
   parameter int CHAIN_LEN = 64
);
   logic                 te_i;
   logic                 scan_clk_i;
   logic                 scan_in_i;
   logic                 scan_out_o;
   logic [CHAIN_LEN-1:0] capture_i;
   logic [CHAIN_LEN-1:0] cfg_o;
   logic                 cfg_valid_o;
   logic                 err_o;

   modport master (
      output te_i,
      output scan_clk_i,
      output scan_in_i,
      output capture_i,
      input  scan_out_o,
      input  cfg_o,
      input  cfg_valid_o,
      input  err_o
   );

   modport slave (
      input  te_i,
      input  scan_clk_i,
      input  scan_in_i,
      input  capture_i,
      output scan_out_o,
      output cfg_o,
      output cfg_valid_o,
      output err_o
   );
endinterface

// File: rtl/toysram_scan_ctl.sv
// rtl/toysram_scan_ctl.sv - oversampled scan-chain controller: capture status, shift, update config word
// Optional shift-length check enabled by defining TOYSRAM_SCAN_LEN_CHECK_EN.
module toysram_scan_ctl #(
   parameter int                   CHAIN_LEN   = 64,
   parameter int                   SYNC_STAGES = 2,
   parameter logic [CHAIN_LEN-1:0] CFG_RESET   = '0
) (
   input  logic                clock,
   input  logic                resetb,
   toysram_scan_ctl_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_SHIFT   = 2'd2,
      ST_UPDATE  = 2'd3
   } state_t;

   // All three pads use identically deep chains so data stays aligned with the sampled clock.
   logic [SYNC_STAGES-1:0] r_te_sync;
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_sin_sync;
   logic                   r_te_d;
   logic                   r_sclk_d;

   logic                   w_te_r;
   logic                   w_sclk_r;
   logic                   w_sin;
   logic                   w_te_rise;
   logic                   w_sclk_rise;

   state_t                 r_state;
   state_t                 w_next;
   logic                   w_load;
   logic                   w_shift;
   logic                   w_update;
   logic                   w_commit;

   logic [CHAIN_LEN-1:0]   r_shift;
   logic [CHAIN_LEN-1:0]   r_cfg;
   logic                   r_cfg_valid;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_te_sync   <= '0;
         r_sclk_sync <= '0;
         r_sin_sync  <= '0;
         r_te_d      <= 1'b0;
         r_sclk_d    <= 1'b0;
      end else begin
         r_te_sync   <= {r_te_sync[SYNC_STAGES-2:0], bus.te_i};
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.scan_clk_i};
         r_sin_sync  <= {r_sin_sync[SYNC_STAGES-2:0], bus.scan_in_i};
         r_te_d      <= w_te_r;
         r_sclk_d    <= w_sclk_r;
      end
   end

   assign w_te_r      = r_te_sync[SYNC_STAGES-1];
   assign w_sclk_r    = r_sclk_sync[SYNC_STAGES-1];
   assign w_sin       = r_sin_sync[SYNC_STAGES-1];
   assign w_te_rise   = w_te_r & ~r_te_d;
   assign w_sclk_rise = w_sclk_r & ~r_sclk_d;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Leaving SHIFT on te_r low (not only its edge) also covers a TE pulse that ends during CAPTURE.
   always_comb begin
      w_next   = r_state;
      w_load   = 1'b0;
      w_shift  = 1'b0;
      w_update = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_te_rise) begin
               w_next = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            w_load = 1'b1;
            w_next = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (!w_te_r) begin
               w_next = ST_UPDATE;
            end else if (w_sclk_rise) begin
               w_shift = 1'b1;
            end
         end
         ST_UPDATE: begin
            w_update = 1'b1;
            w_next   = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

`ifdef TOYSRAM_SCAN_LEN_CHECK_EN
   localparam int                 CNT_W    = $clog2(CHAIN_LEN + 1) + 1;
   localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(CHAIN_LEN);

   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   logic             w_err_set;

   assign w_commit  = w_update && (r_cnt == CNT_FULL);
   assign w_err_set = w_update && (r_cnt != CNT_FULL) && (r_cnt != '0);

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_load) begin
            r_cnt <= '0;
         end else if (w_shift && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_err_set) begin
            r_err <= 1'b1;
         end
      end
   end

   assign bus.err_o = r_err;
`else
   assign w_commit  = w_update;
   assign bus.err_o = 1'b0;
`endif

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_shift     <= '0;
         r_cfg       <= CFG_RESET;
         r_cfg_valid <= 1'b0;
      end else begin
         r_cfg_valid <= 1'b0;
         if (w_load) begin
            r_shift <= bus.capture_i;
         end else if (w_shift) begin
            r_shift <= {r_shift[CHAIN_LEN-2:0], w_sin};
         end
         if (w_commit) begin
            r_cfg       <= r_shift;
            r_cfg_valid <= 1'b1;
         end
      end
   end

   assign bus.scan_out_o  = r_shift[CHAIN_LEN-1];
   assign bus.cfg_o       = r_cfg;
   assign bus.cfg_valid_o = r_cfg_valid;

endmodule

// File: tb/tb_toysram_scan_ctl.sv
// tb/tb_toysram_scan_ctl.sv - randomized self-checking bench for toysram_scan_ctl against a bit-stream model
// Expectations follow TOYSRAM_SCAN_LEN_CHECK_EN when it is defined.
module tb_toysram_scan_ctl;
   localparam int N = 64;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   toysram_scan_ctl_if #(.CHAIN_LEN(N)) bus ();

   toysram_scan_ctl #(
      .CHAIN_LEN   (N),
      .SYNC_STAGES (2),
      .CFG_RESET   ('0)
   ) dut (
      .clock  (clk),
      .resetb (rst_n),
      .bus    (bus)
   );

   int           n_checks  = 0;
   int           n_pass    = 0;
   int           valid_cnt = 0;
   int           bad_idle  = 0;
   logic [N-1:0] cfg_exp;
   logic         err_exp;
   logic         so;

   task automatic check_val(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   always @(negedge clk) if (bus.cfg_valid_o === 1'b1) valid_cnt++;

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic shift_bit(input logic d, output logic sample);
      bus.scan_in_i = d;
      wait_clk(6);
      sample = bus.scan_out_o;
      bus.scan_clk_i = 1'b1;
      wait_clk(6);
      bus.scan_clk_i = 1'b0;
   endtask

   // Model: the chain is a window over the bit stream (captured word MSB first, then shifted-in bits).
   task automatic do_scan(input logic [N-1:0] cap, input int n, input logic [N-1:0] din, input string tag);
      logic         stream[$];
      logic [N-1:0] obs_w = '0;
      logic [N-1:0] exp_w = '0;
      logic [N-1:0] chain;
      logic         s;
      bit           upd;
      for (int i = N - 1; i >= 0; i--) stream.push_back(cap[i]);
      for (int k = 0; k < n; k++) stream.push_back(din[N-1-(k%N)]);

      bus.capture_i = cap;
      valid_cnt = 0;
      bus.te_i = 1'b1;
      wait_clk(8);
      for (int k = 0; k < n; k++) begin
         shift_bit(din[N-1-(k%N)], s);
         if (k < N) begin
            obs_w = {obs_w[N-2:0], s};
            exp_w = {exp_w[N-2:0], stream[k]};
         end
      end
      wait_clk(6);
      bus.te_i = 1'b0;
      wait_clk(12);

      for (int i = 0; i < N; i++) chain[N-1-i] = stream[stream.size()-N+i];
`ifdef TOYSRAM_SCAN_LEN_CHECK_EN
      upd = (n == N);
      if (n != 0 && n != N) err_exp = 1'b1;
`else
      upd = 1'b1;
`endif
      if (upd) cfg_exp = chain;

      if (n > 0) check_val({tag, "/scan_out_seq"}, obs_w, exp_w);
      check_val({tag, "/cfg_o"}, bus.cfg_o, cfg_exp);
      check_val({tag, "/cfg_valid_pulses"}, N'(valid_cnt), N'(upd));
      check_val({tag, "/err_o"}, N'(bus.err_o), N'(err_exp));
      check_val({tag, "/scan_out_final"}, N'(bus.scan_out_o), N'(chain[N-1]));
   endtask

   initial begin
      int n_tab[7] = '{0, 1, 63, 64, 64, 65, 0};
      int idx;
      int n;
      bus.te_i       = 1'b0;
      bus.scan_clk_i = 1'b0;
      bus.scan_in_i  = 1'b0;
      bus.capture_i  = '0;
      cfg_exp        = '0;
      err_exp        = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;

      repeat (500) begin
         @(negedge clk);
         if (bus.scan_out_o !== 1'b0 || bus.cfg_o !== '0 || bus.cfg_valid_o !== 1'b0 || bus.err_o !== 1'b0)
            bad_idle++;
      end
      check_val("idle/bad_cycles", N'(bad_idle), '0);
      check_val("idle/cfg_o", bus.cfg_o, '0);
      wait_clk(1);

      do_scan({$urandom, $urandom}, 64, 64'hA5A5_0F0F_1234_5678, "load_pattern");
      do_scan(64'hDEAD_BEEF_0000_FFFF, 64, '0, "readout");
      do_scan({$urandom, $urandom}, 63, {$urandom, $urandom}, "short63");
      do_scan({$urandom, $urandom}, 0, '0, "te_only");

      bus.capture_i = {$urandom, $urandom};
      bus.te_i = 1'b1;
      wait_clk(8);
      repeat (30) shift_bit(1'($urandom), so);
      rst_n = 1'b0;
      bus.te_i = 1'b0;
      wait_clk(3);
      cfg_exp = '0;
      err_exp = 1'b0;
      check_val("midreset/scan_out", N'(bus.scan_out_o), '0);
      check_val("midreset/cfg_o", bus.cfg_o, '0);
      check_val("midreset/cfg_valid", N'(bus.cfg_valid_o), '0);
      check_val("midreset/err_o", N'(bus.err_o), '0);
      rst_n = 1'b1;
      wait_clk(10);
      do_scan({$urandom, $urandom}, 64, {$urandom, $urandom}, "after_reset");

      for (int r = 0; r < 6; r++) begin
         idx = int'($urandom_range(0, 6));
         n = (idx == 6) ? int'($urandom_range(1, 70)) : n_tab[idx];
         do_scan({$urandom, $urandom}, n, {$urandom, $urandom}, $sformatf("rand%0d_n%0d", r, n));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
